divisor_test_sequencer: RTL and testbench

// Hardware initiator for the Start/Ack search-engine protocol (largest-divisible-by-7 unit and similar).
// - Receives a 16-byte data set over a valid/ready byte stream.
// - Writes the bytes into the engine's 16x8 memory, pulses Start, and waits for DONE_F or DONE_NF.
// - Captures Max, the found flag and the elapsed clock count, then pulses Ack.
// - Presents the result upstream on a valid/ready port.

---
 rtl/divisor_test_sequencer.sv | 171 +++++++++++++++++
 tb/tb_divisor_test_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/divisor_test_sequencer.sv
// Initiator for the Start/Ack search-engine protocol: streams a data set into the
// engine memory, runs the engine, captures its result and reports it upstream.
module divisor_test_sequencer #(
  parameter int N_WORDS = 16,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic                       mem_wr_en_o,
  output logic [$clog2(N_WORDS)-1:0] mem_addr_o,
  output logic [WIDTH-1:0]           mem_data_o,
  output logic                       start_o,
  output logic                       ack_o,
  input  logic                       qdf_i,
  input  logic                       qdnf_i,
  input  logic [WIDTH-1:0]           max_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [WIDTH-1:0]           res_max_o,
  output logic                       res_found_o,
  output logic                       res_timeout_o,
  output logic                       res_err_o,
  output logic [CNT_W-1:0]           res_clocks_o,
  output logic                       q_load_o,
  output logic                       q_start_o,
  output logic                       q_wait_o,
  output logic                       q_ack_o,
  output logic                       q_rep_o
);

  localparam int AW = $clog2(N_WORDS);

  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  localparam logic [AW-1:0]    LAST_ADDR = AW'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_max_q, res_max_d;
  logic             res_found_q, res_found_d;
  logic             res_timeout_q, res_timeout_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] res_clocks_q, res_clocks_d;

  logic             accept_s;
  logic             done_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Handshake strobes are gated by reset so nothing leaks out while it is held low.
  assign in_ready_o  = rst_ni & (state_q == ST_LOAD);
  assign accept_s    = in_valid_i & in_ready_o;
  assign mem_wr_en_o = accept_s;
  assign mem_addr_o  = wcnt_q;
  assign mem_data_o  = in_data_i;
  assign start_o     = rst_ni & (state_q == ST_START);
  assign ack_o       = rst_ni & (state_q == ST_ACK);
  assign res_valid_o = (state_q == ST_REPORT);
  assign done_s      = qdf_i | qdnf_i;
  assign cnt_inc_s   = cnt_q + CNT_W'(1);

  assign q_load_o    = (state_q == ST_LOAD);
  assign q_start_o   = (state_q == ST_START);
  assign q_wait_o    = (state_q == ST_WAIT);
  assign q_ack_o     = (state_q == ST_ACK);
  assign q_rep_o     = (state_q == ST_REPORT);

  assign res_max_o     = res_max_q;
  assign res_found_o   = res_found_q;
  assign res_timeout_o = res_timeout_q;
  assign res_err_o     = res_err_q;
  assign res_clocks_o  = res_clocks_q;

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    cnt_d         = cnt_q;
    res_max_d     = res_max_q;
    res_found_d   = res_found_q;
    res_timeout_d = res_timeout_q;
    res_err_d     = res_err_q;
    res_clocks_d  = res_clocks_q;
    case (state_q)
      ST_LOAD: begin
        if (accept_s) begin
          if (wcnt_q == LAST_ADDR) begin
            wcnt_d  = '0;
            state_d = ST_START;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done sample on the final permitted clock still wins over the timeout.
        if (done_s) begin
          res_max_d    = max_i;
          res_found_d  = qdf_i & ~qdnf_i;
          res_err_d    = qdf_i & qdnf_i;
          res_clocks_d = cnt_inc_s;
          state_d      = ST_ACK;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          res_timeout_d = 1'b1;
          res_found_d   = 1'b0;
          res_max_d     = '0;
          res_clocks_d  = TIMEOUT_C;
          state_d       = ST_REPORT;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_ACK: begin
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (res_ready_i) begin
          res_max_d     = '0;
          res_found_d   = 1'b0;
          res_timeout_d = 1'b0;
          res_err_d     = 1'b0;
          res_clocks_d  = '0;
          state_d       = ST_LOAD;
        end else begin
          state_d = ST_REPORT;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_LOAD;
      wcnt_q        <= '0;
      cnt_q         <= '0;
      res_max_q     <= '0;
      res_found_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_err_q     <= 1'b0;
      res_clocks_q  <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      cnt_q         <= cnt_d;
      res_max_q     <= res_max_d;
      res_found_q   <= res_found_d;
      res_timeout_q <= res_timeout_d;
      res_err_q     <= res_err_d;
      res_clocks_q  <= res_clocks_d;
    end
  end

endmodule

// File: tb/tb_divisor_test_sequencer.sv
// Directed bench for divisor_test_sequencer: table of engine scenarios plus
// hand-written reset-during-run sequences, with a behavioural engine model.
module tb_divisor_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_wr_en, start, ack, qdf, qdnf, res_valid, res_ready;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_data, max_v, res_max;
  logic        res_found, res_timeout, res_err;
  logic [15:0] res_clocks;
  logic        q_load, q_start, q_wait, q_ack, q_rep;

  always #5 clk = ~clk;

  divisor_test_sequencer #(.N_WORDS(16), .WIDTH(8), .CNT_W(16), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .start_o(start), .ack_o(ack), .qdf_i(qdf), .qdnf_i(qdnf),
    .max_i(max_v), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_max_o(res_max), .res_found_o(res_found), .res_timeout_o(res_timeout),
    .res_err_o(res_err), .res_clocks_o(res_clocks), .q_load_o(q_load),
    .q_start_o(q_start), .q_wait_o(q_wait), .q_ack_o(q_ack), .q_rep_o(q_rep)
  );

  typedef struct {
    int         mode;   // 0 Qdf, 1 Qdnf, 2 both, 3 never done
    int         delay;  // WAIT clock on which done is raised
    logic [7:0] max;
    int         gap;
    int         hold;
    logic       found, err, tmo;
    int         clocks;
    logic [7:0] rmax;
    int         acks;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] data_tab[16];
  int         tests = 0, fails = 0;
  int         eng_mode = 3, eng_delay = 1, eng_cnt = 0;
  int         wr_cnt = 0, wr_err = 0, start_cnt = 0, ack_cnt = 0, viol = 0;

  // Engine model: counts WAIT clocks since Start, raises done on the chosen clock.
  always @(posedge clk) begin
    if (start) eng_cnt <= 0;
    else if (q_wait) eng_cnt <= eng_cnt + 1;
  end

  always_comb begin
    qdf  = 1'b0;
    qdnf = 1'b0;
    if (q_wait && eng_cnt == eng_delay - 1) begin
      qdf  = (eng_mode == 0) || (eng_mode == 2);
      qdnf = (eng_mode == 1) || (eng_mode == 2);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt = 0;
      wr_err = 0;
    end else begin
      if (mem_wr_en) begin
        if (mem_addr !== 4'(wr_cnt % 16) || mem_data !== data_tab[wr_cnt % 16]) wr_err++;
        wr_cnt++;
      end
      if (start) start_cnt++;
      if (ack) ack_cnt++;
      if ((in_ready && res_valid) || (start && ack) || (start && !q_start) || (ack && !q_ack) ||
          ($countones({q_load, q_start, q_wait, q_ack, q_rep}) != 1)) viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_bytes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_data  = data_tab[i];
      in_valid = 1'b1;
      if (gap != 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int          s0, a0, w0, e0, k, unstable;
    logic [27:0] snap;
    eng_mode  = vecs[v].mode;
    eng_delay = vecs[v].delay;
    max_v     = vecs[v].max;
    s0 = start_cnt; a0 = ack_cnt; w0 = wr_cnt; e0 = wr_err;
    load_bytes(16, vecs[v].gap);
    k = 0;
    while (!res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("v%0d report_reached", v), {31'd0, res_valid}, 32'd1);
    check($sformatf("v%0d res_found", v), {31'd0, res_found}, {31'd0, vecs[v].found});
    check($sformatf("v%0d res_err", v), {31'd0, res_err}, {31'd0, vecs[v].err});
    check($sformatf("v%0d res_timeout", v), {31'd0, res_timeout}, {31'd0, vecs[v].tmo});
    check($sformatf("v%0d res_clocks", v), {16'd0, res_clocks}, vecs[v].clocks);
    check($sformatf("v%0d res_max", v), {24'd0, res_max}, {24'd0, vecs[v].rmax});
    snap = {res_max, res_found, res_timeout, res_err, res_clocks};
    unstable = 0;
    for (int h = 0; h < vecs[v].hold; h++) begin
      @(negedge clk);
      if ({res_max, res_found, res_timeout, res_err, res_clocks} !== snap ||
          res_valid !== 1'b1 || in_ready !== 1'b0 || start !== 1'b0) unstable++;
    end
    check($sformatf("v%0d hold_stable", v), unstable, 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check($sformatf("v%0d back_to_load", v), {31'd0, q_load}, 32'd1);
    check($sformatf("v%0d res_cleared", v),
          {3'd0, res_valid, res_max, res_found, res_timeout, res_err, res_clocks}, 32'd0);
    check($sformatf("v%0d start_pulses", v), start_cnt - s0, 32'd1);
    check($sformatf("v%0d ack_pulses", v), ack_cnt - a0, vecs[v].acks);
    check($sformatf("v%0d write_count", v), wr_cnt - w0, 32'd16);
    check($sformatf("v%0d write_errors", v), wr_err - e0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outputs_zero"},
          {10'd0, start, ack, res_valid, in_ready, mem_wr_en, res_max, res_found,
           res_timeout, res_err, mem_addr}, 32'd0);
    check({name, "_clocks_zero"}, {16'd0, res_clocks}, 32'd0);
    check({name, "_state_load"}, {27'd0, q_load, q_start, q_wait, q_ack, q_rep}, 32'h10);
  endtask

  initial begin
    {data_tab[0], data_tab[1], data_tab[2], data_tab[3], data_tab[4], data_tab[5],
     data_tab[6], data_tab[7], data_tab[8], data_tab[9], data_tab[10], data_tab[11],
     data_tab[12], data_tab[13], data_tab[14], data_tab[15]} =
      {8'h34, 8'h97, 8'h64, 8'h04, 8'h90, 8'h83, 8'h23, 8'h34,
       8'h0E, 8'h85, 8'h02, 8'h93, 8'h04, 8'h93, 8'h84, 8'h12};
    //         mode dly max    gap hold found err  tmo  clk rmax   acks
    vecs[0] = '{0, 20, 8'h93, 0, 0, 1'b1, 1'b0, 1'b0, 20, 8'h93, 1};
    vecs[1] = '{1,  7, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0,  7, 8'h00, 1};
    vecs[2] = '{0,  3, 8'h5A, 1, 5, 1'b1, 1'b0, 1'b0,  3, 8'h5A, 1};
    vecs[3] = '{3,  1, 8'hAB, 0, 2, 1'b0, 1'b0, 1'b1, 64, 8'h00, 0};
    vecs[4] = '{2,  1, 8'h77, 0, 0, 1'b0, 1'b1, 1'b0,  1, 8'h77, 1};
    vecs[5] = '{0, 64, 8'h3C, 0, 0, 1'b1, 1'b0, 1'b0, 64, 8'h3C, 1};
    max_v     = 8'h00;
    res_ready = 1'b0;

    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    check_reset_outputs("por");
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(v);

    // Reset after 9 bytes, with In_valid still asserted while reset is low.
    load_bytes(9, 0);
    in_valid = 1'b1;
    in_data  = 8'hC3;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("rst_load_release_q_load", {31'd0, q_load}, 32'd1);
    run_vec(0);

    // Reset mid-WAIT with an engine that never finishes.
    eng_mode = 3;
    load_bytes(16, 0);
    repeat (10) @(negedge clk);
    check("rst_wait_in_wait", {31'd0, q_wait}, 32'd1);
    ack_cnt = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_wait_no_ack", ack_cnt, 32'd0);
    run_vec(1);

    check("protocol_violations", viol, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
